// File: rtl/b06_pkg.sv
// Shared types and constants for the b06 compare/count companion block.
package b06_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HIT
    } cnt_state_t;

    localparam logic [1:0] CC_REF0 = 2'b00;
    localparam logic [1:0] CC_REG  = 2'b01;
    localparam logic [1:0] CC_PREV = 2'b10;
    localparam logic [1:0] CC_ZERO = 2'b11;

    localparam int DW_DEF = 8;
    localparam int CW_DEF = 4;

endpackage

// File: rtl/b06_term_cnt.sv
// Enable-gated terminal counter: counts up to TERM, holds there with cont_eql set,
// and returns to zero whenever enable_count drops.
module b06_term_cnt
    import b06_pkg::*;
#(
    parameter int CW   = CW_DEF,
    parameter int TERM = 4
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          enable_count,
    output logic [CW-1:0] count,
    output logic          cont_eql
);

    localparam logic [CW-1:0] TERM_C = CW'(TERM);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    // A terminal count above the counter's range would make the count wrap.
    generate
        if (TERM < 0 || TERM > (1 << CW) - 1) begin : g_bad_term
            $error("b06_term_cnt: TERM out of range for CW");
        end
    endgenerate

    cnt_state_t state;

    // NOTE: every register here is state, so only non-blocking assignments are used;
    // a blocking assignment would let later statements see the new value this cycle.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= IDLE;
            count    <= '0;
            cont_eql <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable_count) begin
                        if (TERM_C == '0) begin
                            state    <= HIT;
                            count    <= '0;
                            cont_eql <= 1'b1;
                        end else begin
                            count <= ONE_C;
                            if (TERM_C == ONE_C) begin
                                state    <= HIT;
                                cont_eql <= 1'b1;
                            end else begin
                                state    <= RUN;
                                cont_eql <= 1'b0;
                            end
                        end
                    end else begin
                        count    <= '0;
                        cont_eql <= 1'b0;
                    end
                end
                RUN: begin
                    if (!enable_count) begin
                        state    <= IDLE;
                        count    <= '0;
                        cont_eql <= 1'b0;
                    end else begin
                        count <= count + ONE_C;
                        if (count + ONE_C == TERM_C) begin
                            state    <= HIT;
                            cont_eql <= 1'b1;
                        end
                    end
                end
                HIT: begin
                    if (!enable_count) begin
                        state    <= IDLE;
                        count    <= '0;
                        cont_eql <= 1'b0;
                    end else begin
                        count    <= TERM_C;
                        cont_eql <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    count    <= '0;
                    cont_eql <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/b06_cmp_cnt.sv
// Produces eql/cont_eql for the b06 controller and edge-detects its ackout.
// Optional two-sample match filter on eql: define B06_EQL_FILTER_EN.
module b06_cmp_cnt
    import b06_pkg::*;
#(
    parameter int             DW   = DW_DEF,
    parameter int             CW   = CW_DEF,
    parameter int             TERM = 4,
    parameter logic [DW-1:0]  REF0 = 8'hA5
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          enable_count,
    input  logic [1:0]    cc_mux,
    input  logic          ackout,
    input  logic [DW-1:0] data_in,
    input  logic          data_valid,
    input  logic          ref_load,
    output logic          eql,
    output logic          cont_eql,
    output logic [CW-1:0] count,
    output logic          ack_evt
);

    logic [DW-1:0] ref_reg;
    logic [DW-1:0] prev_reg;
    logic [DW-1:0] sel_ref;
    logic          ackout_d;
    logic          match;

    b06_term_cnt #(
        .CW   (CW),
        .TERM (TERM)
    ) u_term_cnt (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable_count (enable_count),
        .count        (count),
        .cont_eql     (cont_eql)
    );

    // NOTE: the default assignment ahead of the case keeps this purely combinational
    // even if a select code is ever left uncovered, so no latch can be inferred.
    always_comb begin
        sel_ref = '0;
        case (cc_mux)
            CC_REF0: sel_ref = REF0;
            CC_REG:  sel_ref = ref_reg;
            CC_PREV: sel_ref = prev_reg;
            CC_ZERO: sel_ref = '0;
            default: sel_ref = '0;
        endcase
    end

    // The compare sees ref_reg/prev_reg as they were before this edge's update.
    assign match = (data_in == sel_ref);

`ifdef B06_EQL_FILTER_EN
    logic match_hist;
`endif

    // NOTE: the reference and previous-sample registers are reset along with the
    // control state, so eql is deterministic for any cc_mux straight out of reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            eql      <= 1'b0;
            ref_reg  <= '0;
            prev_reg <= '0;
`ifdef B06_EQL_FILTER_EN
            match_hist <= 1'b0;
`endif
        end else begin
            if (data_valid) begin
                prev_reg <= data_in;
`ifdef B06_EQL_FILTER_EN
                match_hist <= match;
                eql        <= match & match_hist;
`else
                eql <= match;
`endif
            end
            if (ref_load) begin
                ref_reg <= data_in;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ackout_d <= 1'b0;
            ack_evt  <= 1'b0;
        end else begin
            ackout_d <= ackout;
            ack_evt  <= ackout & ~ackout_d;
        end
    end

endmodule

// File: tb/tb_b06_cmp_cnt.sv
// Self-checking bench for b06_cmp_cnt: directed steps then randomized traffic,
// checked against a run-length / match-streak reference model.
module tb_b06_cmp_cnt;

    localparam int DW   = 8;
    localparam int CW   = 4;
    localparam int TERM = 4;
    localparam logic [DW-1:0] REF0 = 8'hA5;
`ifdef B06_EQL_FILTER_EN
    localparam int NEED = 2;
`else
    localparam int NEED = 1;
`endif

    logic          clock = 1'b0;
    logic          reset_n;
    logic          enable_count;
    logic [1:0]    cc_mux;
    logic          ackout;
    logic [DW-1:0] data_in;
    logic          data_valid;
    logic          ref_load;
    logic          eql;
    logic          cont_eql;
    logic [CW-1:0] count;
    logic          ack_evt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int            run_len;
    int            streak;
    logic [DW-1:0] m_ref;
    logic [DW-1:0] m_prev;
    logic          m_ack_d;
    logic          m_ack_evt;

    always #5 clock = ~clock;

    b06_cmp_cnt #(
        .DW   (DW),
        .CW   (CW),
        .TERM (TERM),
        .REF0 (REF0)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable_count (enable_count),
        .cc_mux       (cc_mux),
        .ackout       (ackout),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .ref_load     (ref_load),
        .eql          (eql),
        .cont_eql     (cont_eql),
        .count        (count),
        .ack_evt      (ack_evt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rn, input logic en, input logic [1:0] cc, input logic ack,
                         input logic [DW-1:0] d, input logic dv, input logic rl);
        reset_n      = rn;
        enable_count = en;
        cc_mux       = cc;
        ackout       = ack;
        data_in      = d;
        data_valid   = dv;
        ref_load     = rl;
    endtask

    // Advance one clock, update the model from the inputs seen at that edge, then check.
    task automatic step(input string tag);
        logic [DW-1:0] ref_sel;
        int            exp_count;
        @(posedge clock);
        if (!reset_n) begin
            run_len   = 0;
            streak    = 0;
            m_ref     = '0;
            m_prev    = '0;
            m_ack_d   = 1'b0;
            m_ack_evt = 1'b0;
        end else begin
            run_len = enable_count ? ((run_len < 1000) ? run_len + 1 : run_len) : 0;
            if (data_valid) begin
                case (cc_mux)
                    2'b00:   ref_sel = REF0;
                    2'b01:   ref_sel = m_ref;
                    2'b10:   ref_sel = m_prev;
                    default: ref_sel = '0;
                endcase
                streak = (data_in == ref_sel) ? streak + 1 : 0;
                m_prev = data_in;
            end
            if (ref_load) m_ref = data_in;
            m_ack_evt = ackout & ~m_ack_d;
            m_ack_d   = ackout;
        end
        #1;
        exp_count = (run_len > TERM) ? TERM : run_len;
        check({tag, ".count"},    32'(count),    32'(exp_count));
        check({tag, ".cont_eql"}, 32'(cont_eql), 32'(run_len > 0 && run_len >= TERM));
        check({tag, ".eql"},      32'(eql),      32'(streak >= NEED));
        check({tag, ".ack_evt"},  32'(ack_evt),  32'(m_ack_evt));
    endtask

    initial begin
        logic [DW-1:0] d;

        // Reset held two cycles with enable and valid active
        drive(1'b0, 1'b1, 2'b00, 1'b0, 8'hA5, 1'b1, 1'b0);
        step("rst0");
        step("rst1");
        drive(1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
        step("rst_rel");

        // Terminal count: 1,2,3,4 then hold, then drop
        drive(1'b1, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step("term");
        enable_count = 1'b0;
        step("term_drop");

        // Abort mid-run at count=2
        enable_count = 1'b1;
        step("abort1");
        step("abort2");
        enable_count = 1'b0;
        step("abort_off");
        enable_count = 1'b1;
        step("abort_re");
        enable_count = 1'b0;
        step("abort_idle");

        // Compare against REF0
        drive(1'b1, 1'b0, 2'b00, 1'b0, 8'hA5, 1'b1, 1'b0);
        step("cmp_ref0");
        // Load 3C into ref_reg (no sample), then compare with cc_mux=01
        drive(1'b1, 1'b0, 2'b01, 1'b0, 8'h3C, 1'b0, 1'b1);
        step("ref_load");
        drive(1'b1, 1'b0, 2'b01, 1'b0, 8'h3C, 1'b1, 1'b0);
        step("cmp_reg");
        // Load and compare in the same cycle: compare sees the old ref_reg
        drive(1'b1, 1'b0, 2'b01, 1'b0, 8'h77, 1'b1, 1'b1);
        step("cmp_reg_old");
        // Previous-sample compare: 11 then 11
        drive(1'b1, 1'b0, 2'b10, 1'b0, 8'h11, 1'b1, 1'b0);
        step("cmp_prev1");
        step("cmp_prev2");
        // Zero reference
        drive(1'b1, 1'b0, 2'b11, 1'b0, 8'h00, 1'b1, 1'b0);
        step("cmp_zero");
        step("cmp_zero2");

        // Hold: no valid samples while cc_mux and data move around
        drive(1'b1, 1'b0, 2'b00, 1'b0, 8'h5A, 1'b0, 1'b0);
        step("hold0");
        cc_mux = 2'b01;
        step("hold1");
        cc_mux = 2'b10;
        step("hold2");

        // Filter-style sequence: A5, A5, then A4 mismatch
        drive(1'b1, 1'b0, 2'b00, 1'b0, 8'hA5, 1'b1, 1'b0);
        step("flt1");
        step("flt2");
        data_in = 8'hA4;
        step("flt_miss");
        data_valid = 1'b0;

        // ackout 0 -> 1 -> 1 -> 0
        ackout = 1'b1;
        step("ack_rise");
        step("ack_high");
        ackout = 1'b0;
        step("ack_fall");
        step("ack_low");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 4))
                0:       d = REF0;
                1:       d = m_prev;
                2:       d = m_ref;
                3:       d = '0;
                default: d = DW'($urandom);
            endcase
            drive(($urandom_range(0, 40) != 0),
                  ($urandom_range(0, 7) != 0),
                  2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)),
                  d,
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 5) == 0));
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
